// File: rtl/button_ctl_debouncer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// button_ctl_debouncer_pkg : shared ctl codes, button indices, output FSM type
// Revision 1.0
// ---------------------------------------------------------------------------
package button_ctl_debouncer_pkg;

  localparam int NUM_BTNS = 7;

  localparam int BTN_UP       = 6;
  localparam int BTN_LEFT     = 5;
  localparam int BTN_HOME     = 4;
  localparam int BTN_RIGHT    = 3;
  localparam int BTN_DOWN     = 2;
  localparam int BTN_NUM_UP   = 1;
  localparam int BTN_NUM_DOWN = 0;

  localparam logic [NUM_BTNS-1:0] CTL_CURSOR_UP    = 7'b1000000;
  localparam logic [NUM_BTNS-1:0] CTL_CURSOR_LEFT  = 7'b0100000;
  localparam logic [NUM_BTNS-1:0] CTL_HOME         = 7'b0010000;
  localparam logic [NUM_BTNS-1:0] CTL_CURSOR_RIGHT = 7'b0001000;
  localparam logic [NUM_BTNS-1:0] CTL_CURSOR_DOWN  = 7'b0000100;
  localparam logic [NUM_BTNS-1:0] CTL_NUMBER_UP    = 7'b0000010;
  localparam logic [NUM_BTNS-1:0] CTL_NUMBER_DOWN  = 7'b0000001;
  localparam logic [NUM_BTNS-1:0] CTL_WAITING      = 7'b0000000;

  localparam logic [NUM_BTNS-1:0] REPEATABLE_MASK  = 7'b0000011;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } out_state_t;

  // One-hot of the highest set bit; ascending scan so the top bit wins.
  function automatic logic [NUM_BTNS-1:0] pick_highest(input logic [NUM_BTNS-1:0] ev);
    logic [NUM_BTNS-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      if (ev[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_ctl_debouncer_debounce_bit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// button_ctl_debouncer_debounce_bit : 2-flop sync + restartable debounce counter
// Revision 1.0
// ---------------------------------------------------------------------------
module button_ctl_debouncer_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic stable_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync0_q;
  logic          sync1_q;
  logic          stable_q;
  logic          stable_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Any cycle where the synced input agrees with the stable level restarts the interval.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync1_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync1_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync0_q  <= 1'b0;
      sync1_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync0_q  <= raw_i;
      sync1_q  <= sync0_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule
`default_nettype wire

// File: rtl/button_ctl_debouncer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// button_ctl_debouncer : debounced pushbuttons -> one-hot ctl command pulses
// Revision 1.0
// ---------------------------------------------------------------------------
module button_ctl_debouncer
  import button_ctl_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] ctl,
  output logic [NUM_BTNS-1:0] btn_level
);

  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW      = $clog2(RPT_MAX + 1);
  localparam int HW      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic [NUM_BTNS-1:0] stable;
  logic [NUM_BTNS-1:0] stable_prev_q;
  logic [NUM_BTNS-1:0] rise;
  logic [NUM_BTNS-1:0] rpt_ev;
  logic [NUM_BTNS-1:0] ev;

  out_state_t          state_q;
  logic [HW-1:0]       hold_q;
  logic [NUM_BTNS-1:0] ctl_q;

  for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
    button_ctl_debouncer_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i   (clk),
      .rst_ni  (resetn),
      .raw_i   (btn_raw[i]),
      .stable_o(stable[i])
    );

    if (REPEATABLE_MASK[i]) begin : g_rpt
      logic [RW-1:0] tmr_q;
      logic [RW-1:0] tmr_d;
      logic          first_q;
      logic          first_d;
      logic          fire;

      // Timer is zero while released, so it starts counting on the press-event cycle.
      always_comb begin
        fire    = stable[i] && (tmr_q == (first_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD)));
        tmr_d   = tmr_q + 1'b1;
        first_d = first_q;
        if (!stable[i]) begin
          tmr_d   = '0;
          first_d = 1'b1;
        end else if (fire) begin
          tmr_d   = RW'(1);
          first_d = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          tmr_q   <= '0;
          first_q <= 1'b1;
        end else begin
          tmr_q   <= tmr_d;
          first_q <= first_d;
        end
      end

      assign rpt_ev[i] = fire;
    end else begin : g_norpt
      assign rpt_ev[i] = 1'b0;
    end
  end

  assign rise = stable & ~stable_prev_q;
  assign ev   = rise | rpt_ev;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stable_prev_q <= '0;
      state_q       <= ST_IDLE;
      hold_q        <= '0;
      ctl_q         <= CTL_WAITING;
    end else begin
      stable_prev_q <= stable;
      case (state_q)
        ST_IDLE: begin
          if (|ev) begin
            ctl_q   <= pick_highest(ev);
            hold_q  <= HW'(HOLD_CYCLES - 1);
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Events seen here are dropped on purpose: no queueing behind a held code.
          if (hold_q == '0) begin
            ctl_q   <= CTL_WAITING;
            state_q <= ST_IDLE;
          end else begin
            hold_q <= hold_q - 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ctl       = ctl_q;
  assign btn_level = stable;

endmodule
`default_nettype wire

// File: tb/tb_button_ctl_debouncer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_button_ctl_debouncer : directed bench with a cycle-level behavioural model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_button_ctl_debouncer;

  localparam int DB = 4;
  localparam int HC = 2;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic [6:0] btn_raw = 7'b0;
  logic [6:0] ctl;
  logic [6:0] btn_level;

  button_ctl_debouncer #(
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES    (HC),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .btn_raw  (btn_raw),
    .ctl      (ctl),
    .btn_level(btn_level)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: values it exposes are what the outputs must be after each edge.
  logic [6:0] m_s1, m_s2, m_stable, m_rise, m_new_rise, m_ev, m_code;
  logic [6:0] exp_ctl = 7'b0;
  logic [6:0] exp_level = 7'b0;
  int m_run[7];
  int m_press[7];
  bit m_armed[7];
  int m_edge, m_free, m_start, m_d;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_s1 = '0; m_s2 = '0; m_stable = '0; m_rise = '0; m_code = '0;
      exp_ctl = '0; exp_level = '0;
      m_edge = 0; m_free = 0; m_start = -1000;
      for (int b = 0; b < 7; b++) begin
        m_run[b] = 0; m_press[b] = 0; m_armed[b] = 1'b0;
      end
    end else begin
      m_edge++;
      m_ev = m_rise;
      for (int b = 0; b < 7; b++) begin
        if (b < 2 && m_stable[b] && m_armed[b]) begin
          m_d = m_edge - m_press[b];
          if (m_d == RD || (m_d > RD && ((m_d - RD) % RP) == 0)) m_ev[b] = 1'b1;
        end
        if (!m_stable[b]) m_armed[b] = 1'b0;
        if (m_rise[b]) begin
          m_armed[b] = 1'b1;
          m_press[b] = m_edge;
        end
      end
      if (m_edge >= m_free && m_ev != 7'b0) begin
        for (int b = 0; b < 7; b++) if (m_ev[b]) m_code = 7'b1 << b;
        m_start = m_edge;
        m_free  = m_edge + HC + 1;
      end
      exp_ctl = (m_edge >= m_start && m_edge < m_start + HC) ? m_code : 7'b0;
      m_new_rise = '0;
      for (int b = 0; b < 7; b++) begin
        if (m_s2[b] != m_stable[b]) begin
          m_run[b]++;
          if (m_run[b] > DB) begin
            m_stable[b]   = m_s2[b];
            m_run[b]      = 0;
            m_new_rise[b] = m_s2[b];
          end
        end else begin
          m_run[b] = 0;
        end
      end
      m_rise = m_new_rise;
      m_s2 = m_s1;
      m_s1 = btn_raw;
      exp_level = m_stable;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_ctl", ctl, exp_ctl);
      check("model_level", btn_level, exp_level);
      check_int("onehot_ctl", ($countones(ctl) > 1) ? 1 : 0, 0);
    end
  end

  int pulses[7] = '{default: 0};
  logic [6:0] ctl_prev = 7'b0;
  always @(negedge clk) begin
    for (int b = 0; b < 7; b++) if (ctl[b] && !ctl_prev[b]) pulses[b]++;
    ctl_prev = ctl;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  int p;

  initial begin
    #2 resetn = 1'b0;
    #1;
    check("reset_ctl", ctl, 7'b0);
    check("reset_level", btn_level, 7'b0);
    cyc(3);
    resetn = 1'b1;
    chk_en = 1'b1;
    cyc(3);

    // 1: clean press of Home, release gives nothing
    btn_raw[4] = 1'b1;
    cyc(7);
    check("t1_level", btn_level, 7'b0010000);
    check("t1_pre", ctl, 7'b0);
    cyc(1); check("t1_pulse0", ctl, 7'b0010000);
    cyc(1); check("t1_pulse1", ctl, 7'b0010000);
    cyc(1); check("t1_end", ctl, 7'b0);
    p = pulses[4];
    btn_raw[4] = 1'b0;
    cyc(15); #1;
    check_int("t1_release_quiet", pulses[4] - p, 0);
    check("t1_level_off", btn_level, 7'b0);

    // 2: bouncing Left then steady
    p = pulses[5];
    for (int r = 0; r < 2; r++) begin
      btn_raw[5] = 1'b1; cyc(2); check("t2_glitch_level", btn_level, 7'b0);
      btn_raw[5] = 1'b0; cyc(2); check("t2_glitch_level", btn_level, 7'b0);
    end
    cyc(4); check("t2_glitch_level", btn_level, 7'b0);
    btn_raw[5] = 1'b1;
    cyc(7); check("t2_pre", ctl, 7'b0);
    cyc(1); check("t2_pulse", ctl, 7'b0100000);
    cyc(20); #1;
    check_int("t2_count", pulses[5] - p, 1);
    btn_raw[5] = 1'b0;
    cyc(15);

    // 3: Up and NumDown together; Up wins, NumDown only via repeat
    p = pulses[0];
    btn_raw[6] = 1'b1; btn_raw[0] = 1'b1;
    cyc(8); check("t3_up0", ctl, 7'b1000000);
    cyc(1); check("t3_up1", ctl, 7'b1000000);
    cyc(1); check("t3_end", ctl, 7'b0);
    cyc(17); check("t3_pre_rpt", ctl, 7'b0);
    cyc(1); check("t3_rpt", ctl, 7'b0000001);
    btn_raw[6] = 1'b0; btn_raw[0] = 1'b0;
    cyc(20); #1;
    check_int("t3_numdown_count", pulses[0] - p, 1);

    // 4: NumUp auto-repeat
    p = pulses[1];
    btn_raw[1] = 1'b1;
    cyc(8); check("t4_press", ctl, 7'b0000010);
    cyc(19); check("t4_pre_rpt", ctl, 7'b0);
    cyc(1); check("t4_rpt1", ctl, 7'b0000010);
    cyc(8); check("t4_rpt2", ctl, 7'b0000010);
    cyc(21);
    btn_raw[1] = 1'b0;
    cyc(30); #1;
    check_int("t4_count", pulses[1] - p, 6);

    // 5: async reset mid-HOLD
    btn_raw[4] = 1'b1;
    cyc(8); check("t5_hold", ctl, 7'b0010000);
    #2 resetn = 1'b0;
    #1;
    check("t5_async_ctl", ctl, 7'b0);
    check("t5_async_level", btn_level, 7'b0);
    cyc(2);
    resetn = 1'b1;
    cyc(7); check("t5_pre", ctl, 7'b0);
    cyc(1); check("t5_repress", ctl, 7'b0010000);
    btn_raw[4] = 1'b0;
    cyc(15);

    // 6: Right arriving during Down's HOLD is dropped
    p = pulses[3];
    btn_raw[2] = 1'b1;
    cyc(1);
    btn_raw[3] = 1'b1;
    cyc(7); check("t6_down0", ctl, 7'b0000100);
    cyc(1); check("t6_down1", ctl, 7'b0000100);
    cyc(1); check("t6_end", ctl, 7'b0);
    cyc(1); check("t6_no_right", ctl, 7'b0);
    cyc(15); #1;
    check_int("t6_right_count", pulses[3] - p, 0);
    btn_raw[2] = 1'b0; btn_raw[3] = 1'b0;
    cyc(15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
